// File: rtl/motor_pwm_if.sv
// Line-tracker to motor-bridge bundle: steering command and wheel scales in,
// bridge pins and observability out.
interface motor_pwm_if;
   logic [2:0] state;
   logic [9:0] mod_left;
   logic [9:0] mod_right;
   logic       pwm_left;
   logic       pwm_right;
   logic       left_in1;
   logic       left_in2;
   logic       right_in1;
   logic       right_in2;
   logic [9:0] duty_left;
   logic [9:0] duty_right;
   logic       period_start;

   modport master (
      output state, mod_left, mod_right,
      input  pwm_left, pwm_right, left_in1, left_in2, right_in1, right_in2,
             duty_left, duty_right, period_start
   );

   modport slave (
      input  state, mod_left, mod_right,
      output pwm_left, pwm_right, left_in1, left_in2, right_in1, right_in2,
             duty_left, duty_right, period_start
   );
endinterface

// File: rtl/motor_pwm_driver.sv
// Two-wheel PWM/H-bridge driver: command decode, shared PWM timebase, and a
// per-wheel slew/dead-time FSM.
module motor_pwm_wheel #(
   parameter int RAMP_STEP   = 64,
   parameter int DEAD_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wrap,
   input  logic       stop_cmd,
   input  logic       req_rev,
   input  logic [9:0] target,
   input  logic [9:0] cnt,
   output logic       pwm,
   output logic       in1,
   output logic       in2,
   output logic [9:0] duty
);
   localparam int DW = $clog2(DEAD_CYCLES + 1);
   localparam logic [9:0] RS = 10'(RAMP_STEP);

   typedef enum logic {RUN, DEAD} wheel_state_t;

   wheel_state_t   st, st_nxt;
   logic           rev, rev_nxt;
   logic [9:0]     applied, applied_nxt, ramped, diff;
   logic [DW-1:0]  dcnt, dcnt_nxt;

   always_comb begin
      ramped = applied;
      diff   = '0;
      if (target > applied) begin
         diff   = target - applied;
         ramped = applied + ((diff > RS) ? RS : diff);
      end else if (target < applied) begin
         diff   = applied - target;
         ramped = applied - ((diff > RS) ? RS : diff);
      end
   end

   always_comb begin
      st_nxt      = st;
      rev_nxt     = rev;
      applied_nxt = applied;
      dcnt_nxt    = dcnt;
      case (st)
         RUN: begin
            if (req_rev != rev) begin
               st_nxt      = DEAD;
               applied_nxt = '0;
               dcnt_nxt    = '0;
            end else if (stop_cmd) begin
               applied_nxt = '0;
            end else if (wrap) begin
               applied_nxt = ramped;
            end
         end
         DEAD: begin
            applied_nxt = '0;
            // Direction is sampled only at exit; mid-coast requests are ignored.
            if (dcnt == DW'(DEAD_CYCLES - 1)) begin
               st_nxt  = RUN;
               rev_nxt = req_rev;
            end else begin
               dcnt_nxt = dcnt + 1'b1;
            end
         end
         default: st_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st      <= RUN;
         rev     <= 1'b0;
         applied <= '0;
         dcnt    <= '0;
         pwm     <= 1'b0;
         in1     <= 1'b0;
         in2     <= 1'b0;
      end else begin
         st      <= st_nxt;
         rev     <= rev_nxt;
         applied <= applied_nxt;
         dcnt    <= dcnt_nxt;
         pwm     <= (st == RUN) && (cnt < applied);
         in1     <= (st == RUN) && !rev;
         in2     <= (st == RUN) && rev;
      end
   end

   assign duty = applied;
endmodule

module motor_pwm_driver #(
   parameter int CLK_DIV     = 4,
   parameter int FULL_DUTY   = 1023,
   parameter int SLOW_DUTY   = 600,
   parameter int SHARP_REV   = 700,
   parameter int RAMP_STEP   = 64,
   parameter int DEAD_CYCLES = 16
) (
   input logic        clk,
   input logic        reset,
   motor_pwm_if.slave bus
);
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [9:0] FULL  = 10'(FULL_DUTY);
   localparam logic [9:0] SLOW  = 10'(SLOW_DUTY);
   localparam logic [9:0] SHARP = 10'(SHARP_REV);

   // Index 0 = left wheel, 1 = right wheel.
   logic [1:0][9:0] base, tgt, duty;
   logic [1:0]      rev_dec, rev_req, pwm, in1, in2;
   logic            stop_dec, stop_r;
   logic [PW-1:0]   presc;
   logic [9:0]      cnt;
   logic            tick, wrap, period_start;

   always_comb begin
      base     = '0;
      rev_dec  = '0;
      stop_dec = 1'b0;
      case (bus.state)
         3'b010:  base = {FULL, FULL};
         3'b000:  base = {FULL, SLOW};
         3'b001:  base = {SLOW, FULL};
         3'b100:  begin base = {FULL, SHARP}; rev_dec = 2'b01; end
         3'b101:  begin base = {SHARP, FULL}; rev_dec = 2'b10; end
         default: stop_dec = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tgt     <= '0;
         rev_req <= '0;
         stop_r  <= 1'b0;
      end else begin
         tgt[0]  <= 10'((20'(base[0]) * 20'(bus.mod_left)) >> 10);
         tgt[1]  <= 10'((20'(base[1]) * 20'(bus.mod_right)) >> 10);
         rev_req <= rev_dec;
         stop_r  <= stop_dec;
      end
   end

   assign tick = (presc == PW'(CLK_DIV - 1));
   assign wrap = tick && (cnt == 10'd1023);

   always_ff @(posedge clk) begin
      if (reset) begin
         presc        <= '0;
         cnt          <= '0;
         period_start <= 1'b0;
      end else begin
         presc        <= tick ? '0 : presc + 1'b1;
         if (tick) cnt <= cnt + 1'b1;
         period_start <= wrap;
      end
   end

   for (genvar w = 0; w < 2; w++) begin : g_wheel
      motor_pwm_wheel #(.RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)) u_wheel (
         .clk(clk), .reset(reset), .wrap(wrap), .stop_cmd(stop_r),
         .req_rev(rev_req[w]), .target(tgt[w]), .cnt(cnt),
         .pwm(pwm[w]), .in1(in1[w]), .in2(in2[w]), .duty(duty[w])
      );
   end

   assign bus.pwm_left     = pwm[0];
   assign bus.pwm_right    = pwm[1];
   assign bus.left_in1     = in1[0];
   assign bus.left_in2     = in2[0];
   assign bus.right_in1    = in1[1];
   assign bus.right_in2    = in2[1];
   assign bus.duty_left    = duty[0];
   assign bus.duty_right   = duty[1];
   assign bus.period_start = period_start;
endmodule
